hazard_stall_ctrl: RTL and testbench

Pipeline hazard and stall controller for the per-core 5-stage pipeline. It sequences the ID/EX pipeline register and the upstream PC and IF/ID registers.
- Detects load-use hazards and inserts a single bubble.
- Freezes the front of the pipeline while the shared data-memory port is busy.
- Flushes wrong-path instructions on a taken branch.
- Keeps saturating performance counters and a sticky memory-timeout flag.

---
 rtl/hazard_stall_ctrl.sv | 115 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline: load-use bubbles,
// data-memory wait freezes, branch flushes, plus saturating event counters.
module hazard_stall_ctrl #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_bubble,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_BUBBLE = 2'd1,
    MEM_WAIT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]  flush_count_q, flush_count_d;
  logic              lu;

  assign lu = ex_mem_read && (ex_rd_addr != 5'd0) &&
              ((ex_rd_addr == id_rs1_addr) ||
               (id_uses_rs2 && (ex_rd_addr == id_rs2_addr)));

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    pc_stall       = 1'b0;
    if_id_stall    = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_stall    = 1'b0;
    id_ex_bubble   = 1'b0;
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    timeout_d      = timeout_q;
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;

    if (!rst) begin
      if (mem_busy) begin
        // EX is frozen, so branch and load-use are re-judged after release.
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_stall = 1'b1;
        state_d     = MEM_WAIT;
        if (state_q != MEM_WAIT)          wait_cnt_d = WAIT_W'(1);
        else if (wait_cnt_q != WAIT_MAX)  wait_cnt_d = wait_cnt_q + 1'b1;
        if (wait_cnt_d == WAIT_MAX)       timeout_d  = 1'b1;
      end else begin
        // Release from MEM_WAIT evaluates like RUN in the same cycle.
        wait_cnt_d = '0;
        state_d    = RUN;
        if (ex_branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (lu && (state_q != LU_BUBBLE)) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_bubble = 1'b1;
          state_d      = LU_BUBBLE;
        end
      end

      if (pc_stall && (stall_cycles_q != CNT_MAX))
        stall_cycles_d = stall_cycles_q + 1'b1;
      if (if_id_flush && (flush_count_q != CNT_MAX))
        flush_count_d = flush_count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      timeout_q      <= 1'b0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      timeout_q      <= timeout_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign timeout_err  = timeout_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (MAX_WAIT=4, CNT_W=3): vectors push
// expected responses into a queue; a negedge monitor pops and compares.
module tb_hazard_stall_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic             id_uses_rs2, ex_mem_read, ex_branch_taken, mem_busy;
  logic             pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble;
  logic             timeout_err;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  typedef struct {
    int       idx;
    logic [4:0] ctl;  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble}
    logic     to;
    int       sc;
    int       fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   vec_idx  = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1_addr    (id_rs1_addr),
    .id_rs2_addr    (id_rs2_addr),
    .id_uses_rs2    (id_uses_rs2),
    .ex_rd_addr     (ex_rd_addr),
    .ex_mem_read    (ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .mem_busy       (mem_busy),
    .pc_stall       (pc_stall),
    .if_id_stall    (if_id_stall),
    .if_id_flush    (if_id_flush),
    .id_ex_stall    (id_ex_stall),
    .id_ex_bubble   (id_ex_bubble),
    .timeout_err    (timeout_err),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Drive one cycle of inputs (at posedge+1) and queue what the DUT must show.
  task automatic v(input logic r, input logic mr, input int rd, input int rs1,
                   input int rs2, input logic u2, input logic br, input logic busy,
                   input logic [4:0] ctl, input logic to, input int sc, input int fc);
    exp_t e;
    rst             = r;
    ex_mem_read     = mr;
    ex_rd_addr      = 5'(rd);
    id_rs1_addr     = 5'(rs1);
    id_rs2_addr     = 5'(rs2);
    id_uses_rs2     = u2;
    ex_branch_taken = br;
    mem_busy        = busy;
    vec_idx++;
    e.idx = vec_idx; e.ctl = ctl; e.to = to; e.sc = sc; e.fc = fc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("v%0d ctl", e.idx),
              int'({pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble}), int'(e.ctl));
        check($sformatf("v%0d timeout_err", e.idx), int'(timeout_err), int'(e.to));
        check($sformatf("v%0d stall_cycles", e.idx), int'(stall_cycles), e.sc);
        check($sformatf("v%0d flush_count", e.idx), int'(flush_count), e.fc);
        check($sformatf("v%0d stall_and_bubble", e.idx), int'(id_ex_stall & id_ex_bubble), 0);
        check($sformatf("v%0d flush_and_hold", e.idx), int'(if_id_flush & if_id_stall), 0);
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1; ex_mem_read = 1'b0; ex_rd_addr = '0; id_rs1_addr = '0;
    id_rs2_addr = '0; id_uses_rs2 = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
    @(posedge clk);
    #1;

    // Reset forces outputs low despite hostile inputs.
    v(1, 1,5,5,0,0, 1,1, 5'b00000, 0,0,0);
    // Load-use on rs1, then clean cycle.
    v(0, 1,5,5,0,0, 0,0, 5'b11001, 0,0,0);
    v(0, 0,5,5,0,0, 0,0, 5'b00000, 0,1,0);
    // Load-use held for two cycles: the second falls in LU_BUBBLE and is suppressed.
    v(0, 1,5,5,0,0, 0,0, 5'b11001, 0,1,0);
    v(0, 1,5,5,0,0, 0,0, 5'b00000, 0,2,0);
    // Load-use through rs2.
    v(0, 1,9,3,9,1, 0,0, 5'b11001, 0,2,0);
    v(0, 0,0,0,0,0, 0,0, 5'b00000, 0,3,0);
    // No false hazards: rd=x0, rs2 unused, not a load.
    v(0, 1,0,0,0,0, 0,0, 5'b00000, 0,3,0);
    v(0, 1,7,1,7,0, 0,0, 5'b00000, 0,3,0);
    v(0, 0,4,4,0,0, 0,0, 5'b00000, 0,3,0);
    // Branch flush; branch beats load-use and state stays RUN.
    v(0, 0,0,0,0,0, 1,0, 5'b00101, 0,3,0);
    v(0, 1,5,5,0,0, 1,0, 5'b00101, 0,3,1);
    v(0, 1,5,5,0,0, 0,0, 5'b11001, 0,3,2);
    // Branch during LU_BUBBLE.
    v(0, 0,0,0,0,0, 1,0, 5'b00101, 0,4,2);
    v(1, 0,0,0,0,0, 0,0, 5'b00000, 0,4,3);

    // Memory wait 5 cycles with branch+lu pending; flush on release.
    for (int k = 1; k <= 5; k++)
      v(0, 1,5,5,0,0, 1,1, 5'b11010, (k >= 5), k-1, 0);
    v(0, 1,5,5,0,0, 1,0, 5'b00101, 1,5,0);
    v(1, 0,0,0,0,0, 0,0, 5'b00000, 1,5,1);

    // Timeout: 6 busy cycles, flag sets after the 4th and stays.
    for (int k = 1; k <= 6; k++)
      v(0, 0,0,0,0,0, 0,1, 5'b11010, (k >= 5), k-1, 0);
    // Release with load-use evaluates immediately.
    v(0, 1,5,5,0,0, 0,0, 5'b11001, 1,6,0);
    v(0, 0,0,0,0,0, 0,0, 5'b00000, 1,7,0);
    // Stall counter saturates at 7.
    for (int k = 1; k <= 3; k++)
      v(0, 0,0,0,0,0, 0,1, 5'b11010, 1,7,0);
    // Reset mid-MEM_WAIT clears everything.
    v(1, 0,0,0,0,0, 0,1, 5'b00000, 1,7,0);
    v(0, 0,0,0,0,0, 0,0, 5'b00000, 0,0,0);
    // Reset mid-LU_BUBBLE returns to RUN, so load-use is detected again.
    v(0, 1,5,5,0,0, 0,0, 5'b11001, 0,0,0);
    v(1, 1,5,5,0,0, 0,0, 5'b00000, 0,1,0);
    v(0, 1,5,5,0,0, 0,0, 5'b11001, 0,0,0);
    v(0, 0,0,0,0,0, 0,0, 5'b00000, 0,1,0);
    // Wait counter clears on release: two 3-cycle waits never time out.
    for (int k = 1; k <= 3; k++)
      v(0, 0,0,0,0,0, 0,1, 5'b11010, 0, k, 0);
    v(0, 0,0,0,0,0, 0,0, 5'b00000, 0,4,0);
    for (int k = 1; k <= 3; k++)
      v(0, 0,0,0,0,0, 0,1, 5'b11010, 0, 3+k, 0);
    v(0, 0,0,0,0,0, 0,0, 5'b00000, 0,7,0);

    repeat (3) @(posedge clk);
    check("scoreboard_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
